// File: rtl/_sipo_loader8_pkg.sv
// Shared constants for the serial loader and its downstream register bank.
// Holds the FSM state encoding, default word width and counter sizing helper.
package _sipo_loader8_pkg;

  localparam int SIPO_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/_sipo_loader8_shift_reg.sv
// WIDTH-bit serial shift register with enable and async clear.
// Ports: clk, clr_i (async clear), en_i, bit_i, next_o (value after this edge).
module _shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // LSB-first: new bits enter at the top so the
  // first bit ends in [0] after WIDTH shifts.
  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      if (MSB_FIRST != 0)
        sr_d = {sr_q[WIDTH-2:0], bit_i};
      else
        sr_d = {bit_i, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge clr_i) begin
    if (clr_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  // Exposed so the word can be captured on the
  // same edge that samples the final data bit.
  assign next_o = sr_d;

endmodule

// File: rtl/_sipo_loader8.sv
// Serial-in parallel-out loader with valid/ack handshake.
// Ports: clk, reset, start, s_in, ack -> busy, valid, q, parity_err
// (parity_err exists only when SIPO_PARITY_EN is defined).
module _sipo_loader8
  import _sipo_loader8_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_in,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] WLIM = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] sr_next;
  logic             sh_en;
  logic             last_bit;

`ifdef SIPO_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  _shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk    (clk),
    .clr_i  (reset),
    .en_i   (sh_en),
    .bit_i  (s_in),
    .next_o (sr_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    sh_en    = 1'b0;
    last_bit = (cnt_q == LAST);
`ifdef SIPO_PARITY_EN
    par_d  = par_q;
    perr_d = perr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
`ifdef SIPO_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        // Parity bit is not shifted in.
        sh_en = (cnt_q < WLIM);
        cnt_d = cnt_q + CW'(1);
`ifdef SIPO_PARITY_EN
        par_d = par_q ^ s_in;
`endif
        if (last_bit) begin
          state_d = ST_HOLD;
          word_d  = sr_next;
`ifdef SIPO_PARITY_EN
          perr_d  = par_q ^ s_in;
`endif
        end
      end
      ST_HOLD: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef SIPO_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef SIPO_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = (state_q == ST_HOLD);
  assign q     = word_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb__sipo_loader8.sv
// Scoreboard bench for the serial loader: LSB-first and MSB-first
// instances share stimulus; a monitor checks each presented word.
module tb__sipo_loader8;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic clk = 1'b0;
  logic reset, start, s_in, ack;
  logic busy0, valid0, busy1, valid1;
  logic [W-1:0] q0, q1;
`ifdef SIPO_PARITY_EN
  logic pe0, pe1;
`endif

  always #5 clk = ~clk;

  _sipo_loader8 #(.WIDTH(W), .MSB_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .s_in(s_in), .ack(ack),
    .busy(busy0), .valid(valid0), .q(q0)
`ifdef SIPO_PARITY_EN
    , .parity_err(pe0)
`endif
  );

  _sipo_loader8 #(.WIDTH(W), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .s_in(s_in), .ack(ack),
    .busy(busy1), .valid(valid1), .q(q1)
`ifdef SIPO_PARITY_EN
    , .parity_err(pe1)
`endif
  );

  typedef struct {
    logic [W-1:0] ql;
    logic [W-1:0] qm;
    logic         pe;
    int           vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [W-1:0] last_l, last_m;
  logic v_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on each rising valid.
  always @(negedge clk) begin
    if (valid0 && !v_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid0), 32'd0);
      end else begin
        e = sb.pop_front();
        check("q_lsb", 32'(q0), 32'(e.ql));
        check("q_msb", 32'(q1), 32'(e.qm));
        check("valid_cycle", 32'(cyc), 32'(e.vcyc));
        check("valid_msb", 32'(valid1), 32'd1);
`ifdef SIPO_PARITY_EN
        check("perr_lsb", 32'(pe0), 32'(e.pe));
        check("perr_msb", 32'(pe1), 32'(e.pe));
`endif
      end
    end
    v_prev <= valid0;
  end

  function automatic logic [W-1:0] rev(input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = s[i];
    return r;
  endfunction

  // seq[i] is the i-th serial data bit.
  task automatic send_frame(input logic [W-1:0] seq, input logic pbit,
                            input bit noise);
    exp_t x;
    int k;
    @(negedge clk);
    start = 1'b1;
    x.ql = seq;
    x.qm = rev(seq);
    x.pe = (^seq) ^ pbit;
    x.vcyc = cyc + 1 + FR;
    sb.push_back(x);
    last_l = x.ql;
    last_m = x.qm;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < FR; i++) begin
      s_in = (i < W) ? seq[i] : pbit;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        ack   = 1'($urandom_range(0, 1));
      end
      check("busy_shift", 32'(busy0), 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    ack   = 1'b0;
    #1;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("valid_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic do_ack(input logic with_start);
    @(negedge clk);
    ack   = 1'b1;
    start = with_start;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    check("ack_valid", 32'(valid0), 32'd0);
    check("ack_busy", 32'(busy0), 32'd0);
    check("ack_q_kept", 32'(q0), 32'(last_l));
    check("ack_qm_kept", 32'(q1), 32'(last_m));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    s_in  = 1'b0;
    ack   = 1'b0;
    last_l = '0;
    last_m = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_q", 32'(q0), 32'd0);
    check("rst_qm", 32'(q1), 32'd0);
`ifdef SIPO_PARITY_EN
    check("rst_perr", 32'(pe0), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b0);
    check("hold_busy", 32'(busy0), 32'd1);
    do_ack(1'b0);

    send_frame(8'h03, 1'b0, 1'b0);
    do_ack(1'b1);
    repeat (2) @(negedge clk);
    check("no_restart", 32'(busy0), 32'd0);

    // Reset after three sampled bits.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_valid", 32'(valid0), 32'd0);
    check("midrst_q", 32'(q0), 32'd0);
    check("midrst_qm", 32'(q1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);
    do_ack(1'b0);

    send_frame(8'hC3, 1'b0, 1'b1);
    do_ack(1'b0);

    send_frame(8'hA5, 1'b0, 1'b0);
    do_ack(1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    do_ack(1'b0);

    for (int n = 0; n < 16; n++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_ack(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/_sipo_loader8.md
# _sipo_loader8

Serial-in, parallel-out loader that assembles a WIDTH-bit word from a 1-bit serial stream and presents it with a valid/ack handshake. It sits directly upstream of the 8-bit register bank: `q` drives the register's `d` and the consumer loads it while `valid` is high. It has a three-state FSM, a bit counter and a shift register, all on one clock.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2–16.
- `MSB_FIRST`, 0: 0 = first serial bit lands in q[0]; 1 = first serial bit lands in q[WIDTH-1].
- `clk` in 1: rising-edge clock, the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `s_in` in 1: serial data bit, sampled once per cycle in SHIFT.
- `ack` in 1: consumer accepts the word; sampled only in HOLD.
- `busy` out 1: high when the state is not IDLE.
- `valid` out 1: high in HOLD; `q` is stable and complete.
- `q` out WIDTH: assembled word.
- `parity_err` out 1: present only with `SIPO_PARITY_EN`.

## Operation
- States: IDLE, SHIFT, HOLD.
  - IDLE → SHIFT on `start`=1. `s_in` is not sampled in the start cycle. The counter clears to 0.
  - SHIFT: each cycle, shift `s_in` into the internal shift register and increment the counter. After the last frame bit is sampled (WIDTH bits, or WIDTH+1 with parity), go to HOLD and copy the shift register to `q` on the same edge.
  - HOLD → IDLE on `ack`=1.
- `q` changes only on the SHIFT→HOLD edge. After `ack`, `q` holds the last word until the next frame completes. Partial bits are never visible on `q`.
- `start` in SHIFT or HOLD is ignored and not queued.
- `ack` outside HOLD is ignored.
- `start` and `ack` asserted together in HOLD: the ack is taken and the start is dropped. The upstream must re-assert `start` in IDLE.
- Counter width is ceil(log2(WIDTH+2)) bits. It never wraps within a frame and clears on every IDLE→SHIFT transition.

## Timing
- Reset values: state IDLE, `busy`=0, `valid`=0, `q`=0, shift register 0, counter 0, `parity_err`=0.
- Reset mid-frame or mid-HOLD discards all partial data immediately; `q` also returns to 0.
- Latency: `start` is seen at edge N. Data bits are sampled at edges N+1…N+WIDTH. `valid`=1 after edge N+WIDTH (N+WIDTH+1 with parity).
- `ack` seen at edge M → `valid`=0 after edge M. The earliest next `start` is accepted at edge M+1.
- `busy` rises after edge N and falls after the ack edge.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each frame carries one extra even-parity bit after the data bits.
  - `parity_err` = XOR of all data bits XOR the parity bit, registered on the SHIFT→HOLD edge.
  - `parity_err` is valid while `valid` is high and keeps its value like `q`.
  - `q` is loaded regardless of the error.
- `SIPO_PARITY_EN` undefined:
  - The frame is exactly WIDTH bits.
  - The `parity_err` port and its logic are absent.

## Structure
- A shared package holds the state encoding constants (IDLE=2'b00, SHIFT=2'b01, HOLD=2'b10) and the default WIDTH, so the downstream register-bank wrapper uses the same values.
- Sub-module `_shift_reg`: WIDTH-bit shift register with shift-enable, direction selected by MSB_FIRST, and asynchronous clear.
- The FSM and counter stay in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=0: `start`, then `s_in` = 1,0,1,0,0,1,0,1 → `q`=8'hA5 and `valid`=1 exactly 8 cycles after the start edge, `busy`=1 throughout.
- Same bit sequence 1,1,0,0,0,0,0,0 with MSB_FIRST=0 → `q`=8'h03; with MSB_FIRST=1 → `q`=8'hC0.
- In HOLD with `q`=8'hA5, pulse `ack` → `valid`=0 next cycle, `q` stays 8'hA5; `start` and `ack` asserted together → back to IDLE, no new frame.
- Assert `reset` after 3 bits sampled → `busy`=0, `valid`=0, `q`=0 immediately; a following full frame of 8'h5A completes normally.
- Pulse `start` during SHIFT and hold `ack` high during SHIFT → no restart, frame length unchanged, `valid` timing unaffected.
- `SIPO_PARITY_EN`: 8'hA5 then parity bit 0 → `parity_err`=0; 8'hA5 then parity bit 1 → `parity_err`=1, `q`=8'hA5 in both cases.
